// File: rtl/fpmul_op_sequencer_if.sv
// Bundles the producer stream, the multiplier pins and the result stream.
// The sequencer connects through the slave modport; the environment uses master.
interface fpmul_op_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_r_mode;
  logic [31:0]   in_x;
  logic [31:0]   in_y;
  logic [3:0]    r_mode;
  logic [31:0]   fp_X;
  logic [31:0]   fp_Y;
  logic [31:0]   fp_Z;
  logic          ovrf;
  logic          udrf;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_z;
  logic          out_ovrf;
  logic          out_udrf;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_r_mode, in_x, in_y, fp_Z, ovrf, udrf, out_ready,
    output in_ready, r_mode, fp_X, fp_Y, out_valid, out_z, out_ovrf, out_udrf, count
  );

  modport master (
    output in_valid, in_r_mode, in_x, in_y, fp_Z, ovrf, udrf, out_ready,
    input  in_ready, r_mode, fp_X, fp_Y, out_valid, out_z, out_ovrf, out_udrf, count
  );
endinterface

// File: rtl/fpmul_op_sequencer.sv
// Operand FIFO plus a three-state sequencer that feeds the FP32 multiplier,
// holds the operands for MUL_LAT cycles and presents the captured product.
module fpmul_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  fpmul_op_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESULT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [67:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_in_ready;
  logic [LW-1:0] r_wait;
  logic [3:0]    r_mode_q;
  logic [31:0]   r_x;
  logic [31:0]   r_y;
  logic [31:0]   r_out_z;
  logic          r_out_ovrf;
  logic          r_out_udrf;
  logic          r_out_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_capture;
  logic          w_release;
  logic [67:0]   w_head;

  assign w_push = bus.in_valid && r_in_ready;
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_r_mode, bus.in_x, bus.in_y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_wait == LW'(1)) begin
          w_capture    = 1'b1;
          w_state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (bus.out_ready) begin
          w_release = 1'b1;
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_state_next = S_BUSY;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // in_ready tracks the registered occupancy only, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_wait      <= '0;
      r_mode_q    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_out_z     <= '0;
      r_out_ovrf  <= 1'b0;
      r_out_udrf  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < CW'(DEPTH));
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_mode_q <= w_head[67:64];
        r_x      <= w_head[63:32];
        r_y      <= w_head[31:0];
        r_wait   <= LW'(MUL_LAT);
      end else if (r_state == S_BUSY && !w_capture) begin
        r_wait <= r_wait - 1'b1;
      end
      if (w_capture) begin
        r_out_z     <= bus.fp_Z;
        r_out_ovrf  <= bus.ovrf;
        r_out_udrf  <= bus.udrf;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.r_mode    = r_mode_q;
  assign bus.fp_X      = r_x;
  assign bus.fp_Y      = r_y;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_out_z;
  assign bus.out_ovrf  = r_out_ovrf;
  assign bus.out_udrf  = r_out_udrf;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_fpmul_op_sequencer.sv
// Directed bench: two sequencers (MUL_LAT 2 and 3) driving a behavioural multiplier,
// results checked in order against a per-instance scoreboard.
module tb_fpmul_op_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpmul_op_sequencer_if #(.DEPTH(4)) a_if ();
  fpmul_op_sequencer_if #(.DEPTH(4)) b_if ();

  fpmul_op_sequencer #(.DEPTH(4), .MUL_LAT(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  fpmul_op_sequencer #(.DEPTH(4), .MUL_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  // Multiplier stand-in: known products for the directed cases, a scramble otherwise.
  function automatic logic [33:0] mul_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [3:0] rm);
    if (x == 32'h3FC0_0000 && y == 32'h4000_0000) return {2'b00, 32'h4040_0000};
    if (x == 32'h7F00_0000 && y == 32'h7F00_0000) return {2'b10, 32'h7F80_0000};
    if (x == 32'h0080_0000 && y == 32'h0080_0000) return {2'b01, 32'h0000_0000};
    return {x[0] & y[1], x[1] & y[0], (x ^ {y[15:0], y[31:16]}) + {28'h0, rm}};
  endfunction

  assign {a_if.ovrf, a_if.udrf, a_if.fp_Z} = mul_model(a_if.fp_X, a_if.fp_Y, a_if.r_mode);
  assign {b_if.ovrf, b_if.udrf, b_if.fp_Z} = mul_model(b_if.fp_X, b_if.fp_Y, b_if.r_mode);

  int n_err = 0;
  int n_checks = 0;
  int n_pop_a = 0;
  int n_pop_b = 0;
  logic [33:0] sb_a[$];
  logic [33:0] sb_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_valid(input string tag);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (a_if.out_valid) break;
    end
    chk(tag, 64'(a_if.out_valid), 64'd1);
  endtask

  // Handshakes are sampled on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n) begin
      if (a_if.in_valid && a_if.in_ready) sb_a.push_back(mul_model(a_if.in_x, a_if.in_y, a_if.in_r_mode));
      if (b_if.in_valid && b_if.in_ready) sb_b.push_back(mul_model(b_if.in_x, b_if.in_y, b_if.in_r_mode));
      if (a_if.out_valid && a_if.out_ready) begin
        chk("a_sb_nonempty", 64'(sb_a.size() != 0), 64'd1);
        if (sb_a.size() != 0) begin
          e = sb_a.pop_front();
          chk("a_result", 64'({a_if.out_ovrf, a_if.out_udrf, a_if.out_z}), 64'(e));
        end
        n_pop_a++;
      end
      if (b_if.out_valid && b_if.out_ready) begin
        chk("b_sb_nonempty", 64'(sb_b.size() != 0), 64'd1);
        if (sb_b.size() != 0) begin
          e = sb_b.pop_front();
          chk("b_result", 64'({b_if.out_ovrf, b_if.out_udrf, b_if.out_z}), 64'(e));
        end
        n_pop_b++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int base;
    int npulse;
    int pulse_t[8];
    logic acc;
    logic [31:0] hold_x;
    logic [31:0] hold_z;

    rst_n = 1'b0;
    a_if.in_valid = 0; a_if.in_r_mode = 0; a_if.in_x = 0; a_if.in_y = 0; a_if.out_ready = 0;
    b_if.in_valid = 0; b_if.in_r_mode = 0; b_if.in_x = 0; b_if.in_y = 0; b_if.out_ready = 0;

    // Reset state
    #3;
    chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
    chk("rst_fp_x", 64'(a_if.fp_X), 64'd0);
    chk("rst_out_z", 64'(a_if.out_z), 64'd0);
    chk("rst_count", 64'(a_if.count), 64'd0);
    chk("rst_in_ready", 64'(a_if.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 64'(a_if.in_ready), 64'd1);

    // Single op latency
    a_if.in_valid = 1; a_if.in_x = 32'h3FC0_0000; a_if.in_y = 32'h4000_0000; a_if.in_r_mode = 0;
    tick();
    a_if.in_valid = 0;
    chk("single_count_e0", 64'(a_if.count), 64'd1);
    tick();
    chk("single_fp_x_e1", 64'(a_if.fp_X), 64'h3FC0_0000);
    chk("single_count_e1", 64'(a_if.count), 64'd0);
    chk("single_valid_e1", 64'(a_if.out_valid), 64'd0);
    tick();
    chk("single_valid_e2", 64'(a_if.out_valid), 64'd0);
    tick();
    chk("single_valid_e3", 64'(a_if.out_valid), 64'd1);
    chk("single_z_e3", 64'(a_if.out_z), 64'h4040_0000);
    chk("single_ovrf_e3", 64'(a_if.out_ovrf), 64'd0);
    a_if.out_ready = 1;
    tick();
    a_if.out_ready = 0;
    chk("single_valid_cleared", 64'(a_if.out_valid), 64'd0);

    // Backpressure fill
    k = 0;
    a_if.in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      a_if.in_x = 32'h3F80_0000 + 32'(k);
      a_if.in_y = 32'h4000_0000 + 32'(k << 4);
      a_if.in_r_mode = 4'(k);
      acc = a_if.in_ready;
      tick();
      if (acc) k++;
    end
    a_if.in_valid = 0;
    chk("fill_accepted", 64'(k), 64'd5);
    chk("fill_in_ready", 64'(a_if.in_ready), 64'd0);
    chk("fill_count", 64'(a_if.count), 64'd4);
    chk("fill_out_valid", 64'(a_if.out_valid), 64'd1);
    hold_x = a_if.fp_X;
    hold_z = a_if.out_z;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_fp_x", 64'(a_if.fp_X), 64'(hold_x));
      chk("hold_out_z", 64'(a_if.out_z), 64'(hold_z));
    end
    base = n_pop_a;
    a_if.out_ready = 1;
    for (int i = 0; i < 60 && n_pop_a < base + 5; i++) tick();
    a_if.out_ready = 0;
    chk("fill_drained", 64'(n_pop_a - base), 64'd5);

    // Overflow / underflow flags
    a_if.out_ready = 1;
    a_if.in_valid = 1; a_if.in_x = 32'h7F00_0000; a_if.in_y = 32'h7F00_0000; a_if.in_r_mode = 0;
    tick();
    a_if.in_x = 32'h0080_0000; a_if.in_y = 32'h0080_0000;
    tick();
    a_if.in_valid = 0;
    wait_a_valid("ovf_wait");
    chk("ovf_ovrf", 64'(a_if.out_ovrf), 64'd1);
    chk("ovf_udrf", 64'(a_if.out_udrf), 64'd0);
    chk("ovf_z", 64'(a_if.out_z), 64'h7F80_0000);
    wait_a_valid("udf_wait");
    chk("udf_udrf", 64'(a_if.out_udrf), 64'd1);
    chk("udf_ovrf", 64'(a_if.out_ovrf), 64'd0);
    chk("udf_z", 64'(a_if.out_z), 64'd0);
    tick();
    a_if.out_ready = 0;

    // Throughput, MUL_LAT=3
    b_if.out_ready = 1;
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 4) begin
        b_if.in_valid = 1;
        b_if.in_x = 32'h4100_0000 + 32'(i * 3);
        b_if.in_y = 32'h4080_0000 + 32'(i * 5);
        b_if.in_r_mode = 4'(i);
      end else begin
        b_if.in_valid = 0;
      end
      tick();
      if (b_if.out_valid) begin
        if (npulse < 8) pulse_t[npulse] = i;
        npulse++;
      end
    end
    chk("tput_pulses", 64'(npulse), 64'd4);
    for (int j = 0; j < 3; j++) chk("tput_gap", 64'(pulse_t[j+1] - pulse_t[j]), 64'd4);
    chk("tput_popped", 64'(n_pop_b), 64'd4);
    b_if.out_ready = 0;

    // Simultaneous push and pop at count = DEPTH-1
    k = 0;
    a_if.in_valid = 1;
    for (int i = 0; i < 20 && k < 4; i++) begin
      a_if.in_x = 32'h4200_0000 + 32'(k * 7);
      a_if.in_y = 32'h3E00_0000 + 32'(k * 9);
      a_if.in_r_mode = 4'(k + 2);
      acc = a_if.in_ready;
      tick();
      if (acc) k++;
    end
    a_if.in_valid = 0;
    wait_a_valid("sim_wait");
    chk("sim_count_before", 64'(a_if.count), 64'd3);
    base = n_pop_a;
    a_if.in_valid = 1; a_if.in_x = 32'h4321_0000; a_if.in_y = 32'h1234_5678; a_if.in_r_mode = 4'd9;
    a_if.out_ready = 1;
    tick();
    a_if.in_valid = 0;
    chk("sim_count_after", 64'(a_if.count), 64'd3);
    for (int i = 0; i < 60 && n_pop_a < base + 5; i++) tick();
    a_if.out_ready = 0;
    chk("sim_drained", 64'(n_pop_a - base), 64'd5);

    // Asynchronous reset while BUSY with a queued entry
    k = 0;
    a_if.in_valid = 1;
    for (int i = 0; i < 20 && k < 3; i++) begin
      a_if.in_x = 32'h4500_0000 + 32'(k);
      a_if.in_y = 32'h4600_0000 + 32'(k);
      a_if.in_r_mode = 4'(k);
      acc = a_if.in_ready;
      tick();
      if (acc) k++;
    end
    a_if.in_valid = 0;
    wait_a_valid("arst_wait");
    a_if.out_ready = 1;
    tick();
    a_if.out_ready = 0;
    chk("arst_count_pre", 64'(a_if.count), 64'd1);
    #3;
    rst_n = 1'b0;
    sb_a.delete();
    #1;
    chk("arst_out_valid", 64'(a_if.out_valid), 64'd0);
    chk("arst_fp_x", 64'(a_if.fp_X), 64'd0);
    chk("arst_out_z", 64'(a_if.out_z), 64'd0);
    chk("arst_count", 64'(a_if.count), 64'd0);
    chk("arst_in_ready", 64'(a_if.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_rel_in_ready", 64'(a_if.in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arst_no_stale_valid", 64'(a_if.out_valid), 64'd0);
      chk("arst_no_stale_x", 64'(a_if.fp_X), 64'd0);
    end

    chk("end_sb_a_empty", 64'(sb_a.size()), 64'd0);
    chk("end_sb_b_empty", 64'(sb_b.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fpmul_op_sequencer.md
Name: fpmul_op_sequencer

Overview:
Sits directly upstream of the FP32 multiplier. It buffers operand triples (r_mode, X, Y) from a valid/ready producer in a small FIFO. It drives one triple at a time onto the multiplier inputs and holds them stable for MUL_LAT cycles. It then captures fp_Z/ovrf/udrf and presents the result on a valid/ready output, so downstream logic never touches the multiplier pins directly.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, >= 2
MUL_LAT, 2, cycles from operand drive to result sampling; >= 1

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has operand triple
in_ready  out  1  FIFO can accept
in_r_mode  in  4  rounding mode of triple
in_x  in  32  operand X (IEEE-754 single)
in_y  in  32  operand Y
r_mode  out  4  to multiplier
fp_X  out  32  to multiplier
fp_Y  out  32  to multiplier
fp_Z  in  32  from multiplier
ovrf  in  1  from multiplier
udrf  in  1  from multiplier
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_z  out  32  captured product
out_ovrf  out  1  captured overflow flag
out_udrf  out  1  captured underflow flag
count  out  $clog2(DEPTH)+1  FIFO occupancy (excludes in-flight op)

Behaviour:
- Reset (rst_n low, async): FIFO empty, count=0, FSM=IDLE. r_mode, fp_X, fp_Y, out_z, out_ovrf, out_udrf, out_valid are all 0. in_ready=0 while rst_n is low.
- After reset: in_ready = (count < DEPTH). Purely from registered count; no combinational path from out_ready.
- Push on edge with in_valid && in_ready. Pop per FSM. Simultaneous push+pop leaves count unchanged. A full FIFO never accepts, even if a pop occurs the same edge.
- FIFO is registered with no bypass. An entry pushed at edge E is poppable at the earliest at edge E+1.
- FSM:
  - IDLE: if count>0, pop head into r_mode/fp_X/fp_Y, load wait counter = MUL_LAT, go BUSY.
  - BUSY: r_mode/fp_X/fp_Y held stable; counter decrements each edge. On the edge where counter == 1, register fp_Z/ovrf/udrf into out_*, set out_valid=1, go RESULT.
  - RESULT: out_* and operand outputs are frozen while out_valid && !out_ready. On the handshake edge (out_ready=1):
    - if count>0: pop next into operand regs, reload counter, go BUSY, clear out_valid.
    - else: clear out_valid, go IDLE.
- Operand outputs keep their last values in IDLE; they are not zeroed.
- Latency into an empty, idle block:
  - accept at edge E;
  - fp_X valid after E+1;
  - capture at E+1+MUL_LAT;
  - out_valid visible in the following cycle.
- Steady-state throughput with out_ready=1: one result per MUL_LAT+1 cycles.
- Results are strictly in acceptance order. ovrf/udrf pass through unmodified; both may be 1 only if the multiplier drives both.
- Capacity with out_ready held low: DEPTH in FIFO plus 1 in flight (BUSY/RESULT).
- Reset mid-operation discards the FIFO contents, the in-flight op and any pending result. No output glitches to stale data after release.
- count width holds the value DEPTH (no wrap). FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

Test Plan:
1. Async reset: assert rst_n low mid-BUSY, between clock edges -> out_valid, fp_X, out_z, count drop to 0 immediately and in_ready=0. After release, in_ready=1 on the next cycle and FSM=IDLE.
2. Single op, MUL_LAT=2: push X=0x3FC00000, Y=0x40000000, r_mode=0 at edge 0; multiplier model returns 0x40400000. Required: fp_X=0x3FC00000 after edge 1; out_valid=1, out_z=0x40400000, out_ovrf=0 after edge 3; cleared after the out_ready handshake.
3. Backpressure/fill: out_ready=0, in_valid=1 continuously with DEPTH=4 -> exactly 5 triples accepted, then in_ready=0 with count=4. out_z and fp_X stay stable for 10 cycles. Raising out_ready drains all 5 results in order.
4. Flags: X=Y=0x7F000000, model z=0x7F800000, ovrf=1 -> out_ovrf=1, out_udrf=0. Next X=Y=0x00800000, model z=0, udrf=1 -> out_udrf=1, out_ovrf=0.
5. Throughput: 4 back-to-back pushes, out_ready=1, MUL_LAT=3 -> out_valid pulses exactly 4 cycles apart. out_z sequence matches push order.
6. Simultaneous push/pop at count=DEPTH-1 during a RESULT handshake -> count unchanged, no entry lost or duplicated (scoreboard check).
